// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box tables, state geometry, FSM state type and
// byte/column index helpers used by the round datapath blocks.
package aes_pkg;

    localparam int STATE_W  = 128;
    localparam int BYTE_W   = 8;
    localparam int COL_W    = 32;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sb_state_t;

    // Forward S-box, entry 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, entry 0 is the leftmost byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Bit position of byte (row, col) in a packed state.
    function automatic int byte_lsb(input int row, input int col);
        return col * COL_W + row * BYTE_W;
    endfunction

    // Bit position of column col in a packed state.
    function automatic int col_lsb(input int col);
        return col * COL_W;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single combinational AES S-box lookup. With AES_SUBBYTES_INV_EN defined an
// inv select chooses the inverse table; otherwise only the forward table exists.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
`ifdef AES_SUBBYTES_INV_EN
    input  logic              inv,
`endif
    output logic [BYTE_W-1:0] sub
);

    // Table lookup of the substituted byte.
    always_comb begin
`ifdef AES_SUBBYTES_INV_EN
        sub = inv ? INV_SBOX[data] : SBOX[data];
`else
        sub = SBOX[data];
`endif
    end

endmodule

// File: rtl/aes_subbytes_seq.sv
// Iterative AES SubBytes: substitutes COLS_PER_CYCLE columns per clock through
// a shared bank of 4*COLS_PER_CYCLE S-boxes. Result latency is 4/COLS_PER_CYCLE
// edges after accept. Optional macro AES_SUBBYTES_INV_EN adds in_inv to select
// InvSubBytes for the decryption path.
module aes_subbytes_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
`ifdef AES_SUBBYTES_INV_EN
    input  logic               in_inv,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
);

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("aes_subbytes_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    sb_state_t          state_q;
    sb_state_t          state_d;
    logic [1:0]         cnt_q;
    logic [STATE_W-1:0] work_q;
    logic [STATE_W-1:0] res_q;
    logic               accept;
    logic               last_col;
    logic [1:0]         col_idx [COLS_PER_CYCLE];
    logic [COL_W-1:0]   sub_col [COLS_PER_CYCLE];
`ifdef AES_SUBBYTES_INV_EN
    logic               inv_q;
`endif

    // S-box bank: lane g handles column cnt+g; cnt is always a multiple of
    // COLS_PER_CYCLE, so a lane never wraps past column 3 within one cycle.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        assign col_idx[g] = cnt_q + 2'(g);
        for (genvar r = 0; r < 4; r++) begin : g_row
            aes_sbox u_sbox (
                .data (work_q[byte_lsb(r, int'(col_idx[g])) +: BYTE_W]),
`ifdef AES_SUBBYTES_INV_EN
                .inv  (inv_q),
`endif
                .sub  (sub_col[g][r*BYTE_W +: BYTE_W])
            );
        end
    end

    assign last_col  = (int'(cnt_q) + COLS_PER_CYCLE == NUM_COLS);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_state = res_q;

    // Next-state and handshake decode; in_ready is held low during reset.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUSY;
            end
            BUSY: begin
                if (last_col) state_d = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) state_d = in_valid ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) in_ready = 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Capture on accept, then write substituted columns into the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            work_q <= '0;
            res_q  <= '0;
`ifdef AES_SUBBYTES_INV_EN
            inv_q  <= 1'b0;
`endif
        end else if (accept) begin
            cnt_q  <= 2'd0;
            work_q <= in_state;
`ifdef AES_SUBBYTES_INV_EN
            inv_q  <= in_inv;
`endif
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + CNT_STEP;
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                res_q[col_lsb(int'(col_idx[g])) +: COL_W] <= sub_col[g];
            end
        end
    end

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Scoreboard bench for aes_subbytes_seq. Three instances (COLS_PER_CYCLE = 1, 2, 4)
// share the same stimulus; expected results go into per-instance queues and a
// monitor compares them on every output handshake. Define AES_SUBBYTES_INV_EN to
// also exercise the inverse S-box path.
`timescale 1ns/1ps
module tb_aes_subbytes_seq;

    localparam int NDUT = 3;
    localparam logic [127:0] CNT_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] CNT_OUT = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [127:0] ALL_00  = 128'h0;
    localparam logic [127:0] ALL_63  = {16{8'h63}};
    localparam logic [127:0] ALL_53  = {16{8'h53}};
    localparam logic [127:0] ALL_ED  = {16{8'hed}};
    localparam logic [127:0] ALL_11  = {16{8'h11}};

    typedef struct {
        logic [127:0] data;
        int           acc;
        bit           chk;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [127:0]    in_state = '0;
`ifdef AES_SUBBYTES_INV_EN
    logic            in_inv = 1'b0;
`endif
    logic [NDUT-1:0] ir;
    logic [NDUT-1:0] ov;
    logic [127:0]    os [NDUT];

    exp_t            q [NDUT][$];
    logic [127:0]    last_out [NDUT];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_subbytes_seq #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_state(in_state),
`ifdef AES_SUBBYTES_INV_EN
        .in_inv(in_inv),
`endif
        .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]));

    aes_subbytes_seq #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_state(in_state),
`ifdef AES_SUBBYTES_INV_EN
        .in_inv(in_inv),
`endif
        .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]));

    aes_subbytes_seq #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_state(in_state),
`ifdef AES_SUBBYTES_INV_EN
        .in_inv(in_inv),
`endif
        .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]));

    function automatic int lat(input int i);
        return 4 >> i;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Wait (bounded) at a falling edge until every instance can accept.
    task automatic wait_all_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (ir != '1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ir != '1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=%b required=111", ir);
        end
    endtask

    // Issue one state to all instances and record the expected result.
    task automatic send(input logic [127:0] d, input logic [127:0] e, input bit inv, input bit chk);
        wait_all_ready();
        in_valid = 1'b1;
        in_state = d;
`ifdef AES_SUBBYTES_INV_EN
        in_inv   = inv;
`endif
        for (int i = 0; i < NDUT; i++) q[i].push_back('{data: e, acc: cyc + 1, chk: chk});
        @(negedge clk);
        in_valid = 1'b0;
        if (inv) in_state = d;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 128'(q[0].size() + q[1].size() + q[2].size()), 128'd0);
    endtask

    // Monitor: latency on rising out_valid, stability while stalled,
    // single-cycle valid after handshake, and data compare on handshake.
    initial begin
        logic [NDUT-1:0] ov_p;
        logic [NDUT-1:0] hs_p;
        logic [127:0]    os_p [NDUT];
        exp_t            e;
        ov_p = '0;
        hs_p = '0;
        for (int i = 0; i < NDUT; i++) os_p[i] = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                ov_p = '0;
                hs_p = '0;
            end else begin
                for (int i = 0; i < NDUT; i++) begin
                    if (hs_p[i]) check($sformatf("one_cycle_valid_dut%0d", i), 128'(ov[i]), 128'd0);
                    if (ov[i] && !ov_p[i]) begin
                        if (q[i].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious_valid_dut%0d actual=%h required=no_output", i, os[i]);
                        end else begin
                            check($sformatf("latency_dut%0d", i), 128'(cyc - q[i][0].acc), 128'(lat(i)));
                        end
                    end
                    if (ov[i] && ov_p[i] && !hs_p[i])
                        check($sformatf("stall_stable_dut%0d", i), os[i], os_p[i]);
                    hs_p[i] = ov[i] && out_ready;
                    if (hs_p[i] && q[i].size() != 0) begin
                        e = q[i].pop_front();
                        last_out[i] = os[i];
                        if (e.chk) check($sformatf("data_dut%0d", i), os[i], e.data);
                    end
                    ov_p[i] = ov[i];
                    os_p[i] = os[i];
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int n;
        logic [127:0] x;
        logic [127:0] y;

        // Reset behaviour
        repeat (3) @(negedge clk);
        #1 check("in_ready_during_rst", 128'(ir), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 128'(ir), 128'b111);
        check("out_valid_after_rst", 128'(ov), 128'd0);
        for (int i = 0; i < NDUT; i++) check($sformatf("out_state_after_rst_dut%0d", i), os[i], 128'd0);

        // Zero state and counting state
        out_ready = 1'b1;
        send(ALL_00, ALL_63, 1'b0, 1'b1);
        drain();
        send(CNT_IN, CNT_OUT, 1'b0, 1'b1);
        drain();

        // Input changes after accept are ignored
        send(CNT_IN, CNT_OUT, 1'b0, 1'b1);
        in_state = '1;
        @(negedge clk);
        in_state = ALL_11;
        drain();

        // Backpressure, then back-to-back accept on release
        out_ready = 1'b0;
        send(CNT_IN, CNT_OUT, 1'b0, 1'b1);
        n = 0;
        while (ov != '1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("all_done_before_stall", 128'(ov), 128'b111);
        in_valid = 1'b1;
        in_state = ALL_11;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check("stall_in_ready", 128'(ir), 128'd0);
            check("stall_out_valid", 128'(ov), 128'b111);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_state  = ALL_53;
        for (int i = 0; i < NDUT; i++) q[i].push_back('{data: ALL_ED, acc: cyc + 1, chk: 1'b1});
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Reset two cycles into BUSY discards the in-flight state
        send(CNT_IN, CNT_OUT, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) q[i].delete();
        #1 check("in_ready_mid_rst", 128'(ir), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("out_valid_after_mid_rst", 128'(ov), 128'd0);
        check("in_ready_after_mid_rst", 128'(ir), 128'b111);
        for (int i = 0; i < NDUT; i++) check($sformatf("out_state_after_mid_rst_dut%0d", i), os[i], 128'd0);
        repeat (10) @(negedge clk);
        #1 check("no_result_after_mid_rst", 128'(ov), 128'd0);

`ifdef AES_SUBBYTES_INV_EN
        // Inverse path and forward/inverse round trip
        send(ALL_63, ALL_00, 1'b1, 1'b1);
        drain();
        send(ALL_00, ALL_63, 1'b0, 1'b1);
        drain();
        x = {$urandom, $urandom, $urandom, $urandom};
        send(x, '0, 1'b0, 1'b0);
        drain();
        y = last_out[0];
        send(y, x, 1'b1, 1'b1);
        drain();
`else
        x = '0;
        y = x;
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_subbytes_seq.md
Name: aes_subbytes_seq

Overview:
- Iterative AES SubBytes stage. Sits directly upstream of shiftrows in the round datapath.
- Accepts a 128-bit state over a valid/ready handshake and substitutes COLS_PER_CYCLE columns per clock through a shared S-box bank.
- Presents the substituted state to shiftrows with valid/ready.
- Trades area for latency versus a fully parallel 16-S-box SubBytes.

Parameters:
- COLS_PER_CYCLE, 1, columns substituted per cycle. Legal values are 1, 2 and 4; anything else is an elaboration error. S-box instances = 4*COLS_PER_CYCLE. Latency L = 4/COLS_PER_CYCLE.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream state available.
- in_ready  output  1  block can accept a state this cycle.
- in_state  input  128  state to substitute. Byte (row r, col c) is at bits [32c+8r+7 : 32c+8r], the same layout shiftrows uses.
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  substituted state, same byte layout. Meaningful only while out_valid=1.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: FSM=IDLE, col counter=0, working/result registers=0, out_valid=0. in_ready is forced 0 while rst=1 and is 1 in the first cycle after rst deasserts.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 captures in_state into the working register, clears the counter and moves to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge substitutes columns [cnt .. cnt+COLS_PER_CYCLE-1] into the result register and adds COLS_PER_CYCLE to cnt.
  - The edge that writes column 3 moves to DONE.
  - cnt is 2 bits; wrap from 3 to 0 is expected and harmless.
- DONE:
  - out_valid=1 and out_state is stable until handshake.
  - in_ready = out_ready.
  - out_ready=1 with in_valid=0 → IDLE.
  - out_ready=1 with in_valid=1 → capture new state, go to BUSY. This gives zero bubble on the input side.
  - out_ready=0 → hold DONE. in_ready=0, and input stalls.
- Latency: out_valid rises L clock edges after the accepting edge, i.e. 4/2/1 for COLS_PER_CYCLE=1/2/4. Sustained throughput is one state per L+1 cycles with continuous out_ready.
- in_state is sampled only on the accepting edge. Later changes to in_state are ignored.
- in_valid while BUSY is ignored and not lost; upstream must hold it until in_ready.
- rst mid-BUSY or mid-DONE: the in-flight state is discarded, registers take their reset values, and no out_valid pulse is produced.
- Purely byte-wise: no carries, no cross-byte arithmetic.

Optional Feature:
- Macro: AES_SUBBYTES_INV_EN.
- Defined:
  - Adds input port in_inv (1 bit), sampled together with in_state on the accepting edge and held for the whole operation.
  - in_inv=1 selects the inverse S-box (InvSubBytes, for the decryption path); in_inv=0 selects the forward S-box.
- Undefined: the port is absent, only forward S-box logic is built, and the inverse table is not synthesised.

Decomposition:
- Shared package aes_pkg:
  - SBOX and INV_SBOX 256x8 constant tables.
  - localparams STATE_W=128, BYTE_W=8, COL_W=32, NUM_COLS=4.
  - FSM state typedef {IDLE, BUSY, DONE}.
  - Byte/column index helper functions, reused by shiftrows and mixcolumns.
- Sub-module aes_sbox:
  - 8-bit in, 8-bit out, optional inv select under the same macro.
  - Purely combinational table lookup, instantiated 4*COLS_PER_CYCLE times.

Test Plan:
- Zero state: in_state=128'h0 with out_ready=1 → out_state=128'h6363…63 (all sixteen bytes 0x63). out_valid rises exactly L edges after the accept and lasts 1 cycle.
- Counting state: in_state=128'h0f0e0d0c0b0a09080706050403020100 → out_state=128'h76abd7fe2b670130c56f6bf27b777c63. Run for COLS_PER_CYCLE=1, 2, 4.
- Backpressure: hold out_ready=0 for 10 cycles after DONE → out_valid and out_state stable, in_ready=0, and a second in_valid is not accepted. Release out_ready together with in_valid (state all 0x53) → back-to-back accept; next result is all 0xED.
- Reset mid-operation: assert rst two cycles into BUSY → next cycle out_valid=0, out_state=0, in_ready=1. No spurious result appears later.
- Input hold: change in_state during BUSY → result still matches the value sampled at accept.
- With AES_SUBBYTES_INV_EN: in_inv=1, state all 0x63 → all 0x00. Then in_inv=0, all 0x00 → all 0x63. Forward-then-inverse round trip on a random state returns the original.
